// File: rtl/lcd_refresh_controller_if.sv
// rtl/lcd_refresh_controller_if.sv - debug tap inputs and HD44780 pin bundle
interface lcd_refresh_controller_if;
  logic [31:0] pc_word;
  logic [3:0]  sel_idx;
  logic [31:0] sel_word;
  logic        refresh_req;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        init_done;
  logic        frame_done;

  // Controller side: consumes the debug taps, drives the LCD pins and status
  modport master (
    input  pc_word, sel_idx, sel_word, refresh_req,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, init_done, frame_done
  );

  // Board / datapath side
  modport slave (
    output pc_word, sel_idx, sel_word, refresh_req,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, init_done, frame_done
  );
endinterface

// File: rtl/lcd_refresh_controller.sv
// rtl/lcd_refresh_controller.sv - HD44780 16x2 init and continuous PC/debug-word refresh
module lcd_refresh_controller #(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN        = 25,
  parameter int unsigned T_CMD       = 2000,
  parameter int unsigned T_CLEAR     = 82000,
  parameter int unsigned REFRESH_GAP = 500000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  lcd_refresh_controller_if.master  bus
);

  // One timer serves every state, so it is sized for the longest wait
  localparam int unsigned M0    = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int unsigned M1    = (M0 > REFRESH_GAP) ? M0 : REFRESH_GAP;
  localparam int unsigned M2    = (M1 > T_CMD) ? M1 : T_CMD;
  localparam int unsigned M3    = (M2 > T_EN) ? M2 : T_EN;
  localparam int unsigned T_MAX = (M3 > T_SETUP) ? M3 : T_SETUP;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] POWERUP_LAST = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] SETUP_LAST   = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] EN_LAST      = TW'(T_EN - 1);
  localparam logic [TW-1:0] CMD_LAST     = TW'(T_CMD - 1);
  localparam logic [TW-1:0] CLEAR_LAST   = TW'(T_CLEAR - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(REFRESH_GAP - 1);

  // Byte index: 0..3 during init, 0..33 during a frame (0x80, 16 chars, 0xC0, 16 chars)
  localparam logic [5:0] INIT_LAST_IDX  = 6'd3;
  localparam logic [5:0] FRAME_LAST_IDX = 6'd33;

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    STROBE,
    EXEC,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [5:0]     byte_idx_q, byte_idx_d;
  logic           in_frame_q, in_frame_d;
  logic           pending_q, pending_d;
  logic [31:0]    pc_snap_q, pc_snap_d;
  logic [3:0]     idx_snap_q, idx_snap_d;
  logic [31:0]    word_snap_q, word_snap_d;
  logic [7:0]     lcd_data_q, lcd_data_d;
  logic           lcd_rs_q, lcd_rs_d;
  logic           lcd_en_q, lcd_en_d;
  logic           init_done_q, init_done_d;
  logic           frame_done_q, frame_done_d;

  logic           start_frame;
  logic [8:0]     next_byte;
  logic [TW-1:0]  exec_last;
  logic [5:0]     last_idx;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {rs, data} for byte idx of the init sequence or of a frame built from the snapshot
  function automatic logic [8:0] lcd_byte(input logic        frame,
                                          input logic [5:0]  idx,
                                          input logic [31:0] pc,
                                          input logic [3:0]  sidx,
                                          input logic [31:0] sword);
    logic        line2;
    logic [3:0]  c;
    logic [3:0]  sh;
    logic [31:0] w;
    logic [3:0]  nib;
    logic [7:0]  ch;
    line2 = (idx > 6'd17);
    c     = line2 ? 4'(idx - 6'd18) : 4'(idx - 6'd1);
    w     = line2 ? sword : pc;
    sh    = 4'd11 - c;
    nib   = 4'(w >> {sh[2:0], 2'b00});
    case (c)
      4'd0:    ch = line2 ? 8'h53 : 8'h50;
      4'd1:    ch = line2 ? hex_ascii(sidx) : 8'h43;
      4'd2:    ch = 8'h3A;
      4'd3:    ch = 8'h20;
      4'd12, 4'd13, 4'd14, 4'd15: ch = 8'h20;
      default: ch = hex_ascii(nib);
    endcase
    if (!frame) begin
      case (idx[1:0])
        2'd0:    lcd_byte = 9'h038;
        2'd1:    lcd_byte = 9'h00C;
        2'd2:    lcd_byte = 9'h001;
        default: lcd_byte = 9'h006;
      endcase
    end else if (idx == 6'd0) begin
      lcd_byte = 9'h080;
    end else if (idx == 6'd17) begin
      lcd_byte = 9'h0C0;
    end else begin
      lcd_byte = {1'b1, ch};
    end
  endfunction

  // Next-state: power-up wait, per-byte SETUP/STROBE/EXEC, inter-frame gap
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    byte_idx_d   = byte_idx_q;
    in_frame_d   = in_frame_q;
    pending_d    = pending_q | bus.refresh_req;
    pc_snap_d    = pc_snap_q;
    idx_snap_d   = idx_snap_q;
    word_snap_d  = word_snap_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_en_d     = lcd_en_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    next_byte    = lcd_byte(in_frame_q, byte_idx_q + 6'd1, pc_snap_q, idx_snap_q, word_snap_q);
    exec_last    = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;
    last_idx     = in_frame_q ? FRAME_LAST_IDX : INIT_LAST_IDX;

    case (state_q)
      PWR_WAIT: begin
        if (timer_q == POWERUP_LAST) begin
          timer_d    = '0;
          state_d    = SETUP;
          in_frame_d = 1'b0;
          byte_idx_d = 6'd0;
          {lcd_rs_d, lcd_data_d} = lcd_byte(1'b0, 6'd0, 32'h0, 4'h0, 32'h0);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SETUP: begin
        if (timer_q == SETUP_LAST) begin
          timer_d  = '0;
          state_d  = STROBE;
          lcd_en_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STROBE: begin
        if (timer_q == EN_LAST) begin
          timer_d  = '0;
          state_d  = EXEC;
          lcd_en_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      EXEC: begin
        if (timer_q == exec_last) begin
          timer_d = '0;
          if (byte_idx_q != last_idx) begin
            state_d    = SETUP;
            byte_idx_d = byte_idx_q + 6'd1;
            {lcd_rs_d, lcd_data_d} = next_byte;
          end else if (!in_frame_q) begin
            init_done_d = 1'b1;
            start_frame = 1'b1;
          end else begin
            state_d      = GAP;
            frame_done_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (pending_q || bus.refresh_req || timer_q == GAP_LAST) begin
          pending_d   = 1'b0;
          start_frame = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        timer_d = '0;
      end
    endcase

    // Frame entry: freeze the taps so the whole frame shows one coherent picture
    if (start_frame) begin
      state_d     = SETUP;
      timer_d     = '0;
      in_frame_d  = 1'b1;
      byte_idx_d  = 6'd0;
      pc_snap_d   = bus.pc_word;
      idx_snap_d  = bus.sel_idx;
      word_snap_d = bus.sel_word;
      {lcd_rs_d, lcd_data_d} = 9'h080;
    end
  end

  // State registers; asynchronous reset drops EN immediately and restarts from power-up wait
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PWR_WAIT;
      timer_q      <= '0;
      byte_idx_q   <= 6'd0;
      in_frame_q   <= 1'b0;
      pending_q    <= 1'b0;
      pc_snap_q    <= 32'h0;
      idx_snap_q   <= 4'h0;
      word_snap_q  <= 32'h0;
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      byte_idx_q   <= byte_idx_d;
      in_frame_q   <= in_frame_d;
      pending_q    <= pending_d;
      pc_snap_q    <= pc_snap_d;
      idx_snap_q   <= idx_snap_d;
      word_snap_q  <= word_snap_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_en_q     <= lcd_en_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.lcd_data   = lcd_data_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = lcd_en_q;
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// tb/tb_lcd_refresh_controller.sv - self-checking bench for lcd_refresh_controller
module tb_lcd_refresh_controller;
  localparam int T_POWERUP   = 100;
  localparam int T_SETUP     = 2;
  localparam int T_EN        = 4;
  localparam int T_CMD       = 10;
  localparam int T_CLEAR     = 50;
  localparam int REFRESH_GAP = 200;
  localparam int BYTE_CYC    = T_SETUP + T_EN + T_CMD;
  localparam int FRAME_CYC   = 34 * BYTE_CYC;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  lcd_refresh_controller_if bus();

  lcd_refresh_controller #(
    .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .REFRESH_GAP(REFRESH_GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rise;
    logic       rs;
    logic [7:0] d;
  } rec_t;

  rec_t bq[$];
  int   fd_q[$];
  int   cyc = 0;
  int   rel = 0;
  int   rise_cyc = 0;
  int   id_cyc = -1;
  logic en_prev = 1'b0;
  logic id_prev = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every byte on EN falling edge, plus frame_done pulses and init_done rise
  always @(negedge clk) begin
    if (bus.lcd_en && !en_prev) rise_cyc = cyc;
    if (!bus.lcd_en && en_prev) bq.push_back('{rise_cyc, bus.lcd_rs, bus.lcd_data});
    if (bus.frame_done) fd_q.push_back(cyc);
    if (bus.init_done && !id_prev) id_cyc = cyc;
    en_prev = bus.lcd_en;
    id_prev = bus.init_done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic to_cycle(input int k);
    while (cyc < rel + k) @(negedge clk);
  endtask

  task automatic pulse_req();
    bus.refresh_req = 1'b1;
    @(negedge clk);
    bus.refresh_req = 1'b0;
  endtask

  task automatic next_rec(output rec_t r);
    if (bq.size() != 0) begin
      r = bq.pop_front();
    end else begin
      r.rise = -1;
      r.rs   = 1'bx;
      r.d    = 8'hxx;
    end
  endtask

  // Release reset at a falling edge and require quiet outputs for the whole power-up wait
  task automatic release_and_quiet(input string tag);
    logic quiet;
    reset_n = 1'b1;
    rel = cyc;
    bq.delete();
    fd_q.delete();
    id_cyc = -1;
    quiet = 1'b1;
    for (int k = 0; k < T_POWERUP; k++) begin
      to_cycle(k);
      if (bus.lcd_en || bus.lcd_rs || bus.lcd_rw || bus.lcd_data != 8'h00 ||
          bus.init_done || bus.frame_done) quiet = 1'b0;
    end
    check({tag, " powerup quiet"}, quiet, 1'b1);
  endtask

  // Init model: four commands back to back, clear gets the long exec wait
  task automatic check_init(input string tag, output int frame_start);
    logic [7:0] cmds [4];
    rec_t r;
    int   t;
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    t = T_POWERUP;
    for (int i = 0; i < 4; i++) begin
      next_rec(r);
      check($sformatf("%s init%0d", tag, i), {r.rise - rel, r.rs, r.d}, {t + T_SETUP, 1'b0, cmds[i]});
      t += T_SETUP + T_EN + ((cmds[i] == 8'h01) ? T_CLEAR : T_CMD);
    end
    check({tag, " init_done cycle"}, id_cyc - rel, t);
    frame_start = t;
  endtask

  // Frame model: text lines built from the rules, each byte at a fixed 16-cycle pitch
  task automatic check_frame(input string tag, input int start, input logic [31:0] pc,
                             input logic [3:0] si, input logic [31:0] sw);
    string hx, l1, l2;
    rec_t  r;
    logic [8:0] exp;
    int    fd;
    hx = "0123456789ABCDEF";
    l1 = "PC: ";
    l2 = {"S", hx.substr(int'(si), int'(si)), ": "};
    for (int k = 7; k >= 0; k--) begin
      l1 = {l1, hx.substr(int'(pc[k*4 +: 4]), int'(pc[k*4 +: 4]))};
      l2 = {l2, hx.substr(int'(sw[k*4 +: 4]), int'(sw[k*4 +: 4]))};
    end
    l1 = {l1, "    "};
    l2 = {l2, "    "};
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       exp = 9'h080;
      else if (i == 17) exp = 9'h0C0;
      else if (i < 17)  exp = {1'b1, l1[i-1]};
      else              exp = {1'b1, l2[i-18]};
      next_rec(r);
      check($sformatf("%s byte%0d", tag, i), {r.rise - rel, r.rs, r.d},
            {start + T_SETUP + i * BYTE_CYC, exp});
    end
    fd = (fd_q.size() != 0) ? fd_q.pop_front() : -1;
    check({tag, " frame_done cycle"}, fd - rel, start + FRAME_CYC);
  endtask

  initial begin
    int s, s2, s3, s4, s5;
    logic [31:0] pc3, sw3, pc4;
    logic [3:0]  si3;

    bus.refresh_req = 1'b0;
    bus.pc_word  = $urandom;
    bus.sel_idx  = 4'($urandom);
    bus.sel_word = $urandom;
    #1 reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst lcd_data", bus.lcd_data, 8'h00);
    check("rst lcd_rs", bus.lcd_rs, 1'b0);
    check("rst lcd_rw", bus.lcd_rw, 1'b0);
    check("rst lcd_en", bus.lcd_en, 1'b0);
    check("rst init_done", bus.init_done, 1'b0);
    check("rst frame_done", bus.frame_done, 1'b0);

    bus.pc_word  = 32'h0040_001C;
    bus.sel_idx  = 4'h3;
    bus.sel_word = 32'hDEAD_BEEF;
    release_and_quiet("boot");
    to_cycle(T_POWERUP + 115);
    check_init("boot", s);

    // Change PC while the 5th line-1 character is on the bus
    to_cycle(s + 5 * BYTE_CYC + 6);
    bus.pc_word = 32'hFFFF_FFFF;
    to_cycle(s + FRAME_CYC + 8);
    check_frame("f1", s, 32'h0040_001C, 4'h3, 32'hDEAD_BEEF);

    s2 = s + FRAME_CYC + REFRESH_GAP;
    to_cycle(s2 + FRAME_CYC + 8);
    check_frame("f2", s2, 32'hFFFF_FFFF, 4'h3, 32'hDEAD_BEEF);

    pc3 = $urandom;
    si3 = 4'($urandom);
    sw3 = $urandom;
    bus.pc_word  = pc3;
    bus.sel_idx  = si3;
    bus.sel_word = sw3;
    to_cycle(s2 + FRAME_CYC + 20);
    pulse_req();
    s3 = s2 + FRAME_CYC + 21;

    // Inputs for the next frame change mid-frame; two requests collapse into one
    to_cycle(s3 + 80);
    pc4 = $urandom;
    bus.pc_word  = pc4;
    bus.sel_idx  = 4'hF;
    bus.sel_word = 32'h0123_89AF;
    to_cycle(s3 + 200);
    pulse_req();
    to_cycle(s3 + 400);
    pulse_req();
    to_cycle(s3 + FRAME_CYC + 8);
    check_frame("f3", s3, pc3, si3, sw3);

    s4 = s3 + FRAME_CYC + 1;
    to_cycle(s4 + FRAME_CYC + 8);
    check_frame("f4", s4, pc4, 4'hF, 32'h0123_89AF);

    s5 = s4 + FRAME_CYC + REFRESH_GAP;
    to_cycle(s5 + 20 * BYTE_CYC + T_SETUP + 1);
    check("f5 records before reset", bq.size(), 20);
    check("f5 start", (bq.size() > 0) ? bq[0].rise - rel : -1, s5 + T_SETUP);
    check("f5 en before reset", bus.lcd_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst lcd_en", bus.lcd_en, 1'b0);
    check("midrst init_done", bus.init_done, 1'b0);
    check("midrst lcd_data", bus.lcd_data, 8'h00);
    check("midrst lcd_rs", bus.lcd_rs, 1'b0);
    repeat (3) @(negedge clk);

    bus.pc_word  = $urandom;
    bus.sel_idx  = 4'($urandom);
    bus.sel_word = $urandom;
    pc3 = bus.pc_word;
    si3 = bus.sel_idx;
    sw3 = bus.sel_word;
    fork
      release_and_quiet("rerun");
      begin
        @(negedge clk);
        to_cycle(50);
        pulse_req();
      end
    join
    to_cycle(150);
    pulse_req();
    to_cycle(T_POWERUP + 115);
    check_init("rerun", s);
    to_cycle(s + 100);
    pc4 = $urandom;
    bus.pc_word  = pc4;
    bus.sel_word = ~sw3;
    to_cycle(s + FRAME_CYC + 8);
    check_frame("r1", s, pc3, si3, sw3);
    s2 = s + FRAME_CYC + 1;
    to_cycle(s2 + FRAME_CYC + 8);
    check_frame("r2", s2, pc4, si3, ~sw3);
    check("rerun init_done held", bus.init_done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lcd_refresh_controller.md
Name: lcd_refresh_controller

Overview:
- Drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode for the MIPS debug display.
- Runs the power-up init sequence, then refreshes both lines continuously.
- Line 1 shows the PC; line 2 shows the debug word currently picked by the output selector, plus its index.
- Sits between the selector/datapath debug taps and the board LCD pins.

Parameters:
- T_POWERUP, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- T_SETUP, 2: cycles RS/DATA are valid before EN rises.
- T_EN, 25: cycles EN is held high.
- T_CMD, 2000: cycles to wait after EN falls for a normal command or character (40 us).
- T_CLEAR, 82000: cycles to wait after EN falls for the clear command 0x01 (1.64 ms).
- REFRESH_GAP, 500000: idle cycles between frames.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pc_word  in  32  PC value for line 1
- sel_idx  in  4  selector index for line 2
- sel_word  in  32  selected debug word for line 2
- refresh_req  in  1  single-cycle pulse; requests an immediate frame
- lcd_data  out  8  LCD DB[7:0]
- lcd_rs  out  1  0 = command, 1 = character
- lcd_rw  out  1  constant 0
- lcd_en  out  1  LCD enable strobe
- init_done  out  1  high once the init sequence completes; stays high until reset
- frame_done  out  1  one-cycle pulse after the last character of a frame finishes its T_CMD wait

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n is low: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, init_done=0, frame_done=0, pending refresh cleared, FSM in PWR_WAIT.
- Reset asserted mid-transfer aborts immediately: EN drops the same instant. On release the full init is redone.
- Transfer micro-sequence, used for every byte:
  - SETUP: en=0, rs/data driven, T_SETUP cycles.
  - STROBE: en=1, T_EN cycles.
  - EXEC: en=0, rs/data held, T_CMD cycles, or T_CLEAR when the byte is command 0x01.
  - Total length per byte: T_SETUP + T_EN + T_EXEC.
- FSM sequence:
  - PWR_WAIT: wait T_POWERUP cycles, then INIT.
  - INIT: send commands 0x38, 0x0C, 0x01, 0x06 in that order. Set init_done=1 as the FSM moves to FRAME.
  - FRAME: on entry, snapshot pc_word, sel_idx and sel_word into internal registers. The display is generated only from the snapshot, so input changes mid-frame do not show until the next frame.
  - FRAME sends: command 0x80, line 1 (16 chars), command 0xC0, line 2 (16 chars). That is 34 transfers.
  - After the last transfer, pulse frame_done for 1 cycle and go to GAP.
  - GAP: count REFRESH_GAP cycles, then FRAME. A refresh_req, or a pending flag already set, ends GAP early: the FSM goes to FRAME on the next cycle and the flag clears.
- refresh_req outside GAP sets the pending flag. Multiple requests collapse into one. A request during PWR_WAIT or INIT is also held and serviced at the first GAP.
- Line 1 text: "PC: " followed by 8 hex digits of pc_word, MSB nibble first, then 4 spaces.
- Line 2 text: "S", hex(sel_idx), ": ", 8 hex digits of sel_word MSB first, then 4 spaces.
- Hex to ASCII conversion: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10), uppercase.
- All timing counters are wide enough for the largest parameter and never wrap within a state. The character index counts 0..15 per line.
- All outputs are registered; no combinational path from inputs to LCD pins.

Test Plan:
Bench parameters for all scenarios: T_POWERUP=100, T_SETUP=2, T_EN=4, T_CMD=10, T_CLEAR=50, REFRESH_GAP=200. A normal byte therefore takes 16 cycles.
- Reset/power-up:
  - Stimulus: release reset_n.
  - Required: outputs stay at their reset values for 100 cycles; first EN rises at cycle 102 with rs=0, data=0x38.
  - Required init order: 0x38, 0x0C, 0x01, 0x06; the gap after 0x01 is 50 cycles; init_done rises at cycle 100+48+56=204.
- Frame content:
  - Stimulus: pc_word=0x0040_001C, sel_idx=3, sel_word=0xDEAD_BEEF.
  - Required bytes captured on EN falling edges: 0x80, "PC: 0040001C    ", 0xC0, "S3: DEADBEEF    ".
  - Required: rs=1 only on characters; frame_done pulses once, 544 cycles after the frame starts.
- Snapshot coherence:
  - Stimulus: change pc_word to 0xFFFF_FFFF during the 5th line-1 character.
  - Required: the current frame still shows 0040001C; the next frame shows FFFFFFFF.
- Refresh request:
  - Stimulus: refresh_req pulse 20 cycles into GAP.
  - Required: next frame starts 1 cycle later, not 200 cycles later.
  - Stimulus: two pulses during a frame.
  - Required: exactly one early frame follows.
- Mid-operation reset:
  - Stimulus: assert reset_n low while EN is high in a line-2 character.
  - Required: en=0 and init_done=0 immediately; after release, the full init repeats from PWR_WAIT.
- Hex boundary:
  - Stimulus: sel_word=0x0123_89AF, sel_idx=0xF.
  - Required line 2: "SF: 012389AF    ". Confirms the 9→'9' (0x39) and A→'A' (0x41) boundaries.
